// File: rtl/dino_frame_writer.sv
// Per-frame game engine for the dino display: advances the run/jump/duck mode, jump physics and
// cactus scroll on each vga_vs falling edge, then writes the ten sprite position registers over Avalon-MM.
module dino_frame_writer #(
   parameter logic [7:0] DINO_X    = 8'd100,
   parameter logic [7:0] GROUND_Y  = 8'd100,
   parameter logic [7:0] JUMP_V    = 8'd10,
   parameter logic [7:0] GRAVITY   = 8'd1,
   parameter logic [7:0] CAC_START = 8'd250,
   parameter logic [7:0] CAC_Y     = 8'd100,
   parameter logic [7:0] SPEED     = 8'd4,
   parameter logic [7:0] GOD_X     = 8'd100,
   parameter logic [7:0] GOD_Y     = 8'd255,
   parameter logic [7:0] HIDE_XY   = 8'd255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vga_vs,
   input  logic        btn_jump,
   input  logic        btn_duck,
   output logic [8:0]  avm_address,
   output logic [31:0] avm_writedata,
   output logic        avm_write,
   output logic        avm_chipselect,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic [15:0] frame_count
);

   // state    | meaning
   // S_IDLE   | waiting for a vga_vs falling edge
   // S_UPDATE | one cycle: sample buttons, advance game state, load beat 0
   // S_WRITE  | present beat idx until accepted; leave after beat 9
   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_WRITE} ctl_t;
   typedef enum logic [1:0] {M_RUN, M_JUMP, M_DUCK} mode_t;

   ctl_t              state;
   mode_t             mode, mode_n;
   logic [7:0]        y, y_n, cac_x, cac_n;
   logic signed [8:0] vy, vy_n, vy_eff, y_sum;
   logic              jumping;
   logic              vs_q, tick;
   logic [3:0]        idx;

   assign tick           = vs_q & ~vga_vs;
   assign busy           = (state != S_IDLE);
   assign avm_chipselect = avm_write;

   function automatic logic [7:0] reg_value(input logic [3:0] a, input mode_t m,
                                            input logic [7:0] yv, input logic [7:0] cx);
      logic [7:0] v;
      case (a)
         4'd0:    v = (m == M_RUN)  ? DINO_X   : HIDE_XY;
         4'd1:    v = (m == M_RUN)  ? yv       : HIDE_XY;
         4'd2:    v = (m == M_JUMP) ? DINO_X   : HIDE_XY;
         4'd3:    v = (m == M_JUMP) ? yv       : HIDE_XY;
         4'd4:    v = (m == M_DUCK) ? DINO_X   : HIDE_XY;
         4'd5:    v = (m == M_DUCK) ? GROUND_Y : HIDE_XY;
         4'd6:    v = cx;
         4'd7:    v = CAC_Y;
         4'd8:    v = GOD_X;
         4'd9:    v = GOD_Y;
         default: v = 8'd0;
      endcase
      return v;
   endfunction

   // Next game state; only committed in S_UPDATE, so button activity elsewhere is ignored.
   always_comb begin
      mode_n  = mode;
      y_n     = y;
      vy_n    = vy;
      vy_eff  = vy;
      y_sum   = 9'sd0;
      jumping = 1'b0;
      case (mode)
         M_RUN, M_DUCK: begin
            if (btn_jump) begin
               jumping = 1'b1;
               vy_eff  = -$signed({1'b0, JUMP_V});
            end else begin
               mode_n = btn_duck ? M_DUCK : M_RUN;
            end
         end
         default: jumping = 1'b1;
      endcase
      if (jumping) begin
         mode_n = M_JUMP;
         y_sum  = $signed({1'b0, y}) + vy_eff;
         vy_n   = vy_eff + $signed({1'b0, GRAVITY});
         if (vy_eff > 9'sd0 && y_sum >= $signed({1'b0, GROUND_Y})) begin
            y_n    = GROUND_Y;
            vy_n   = 9'sd0;
            mode_n = M_RUN;
         end else begin
            y_n = y_sum[7:0];
         end
      end
      cac_n = (cac_x < SPEED) ? CAC_START : cac_x - SPEED;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         mode          <= M_RUN;
         y             <= GROUND_Y;
         vy            <= 9'sd0;
         cac_x         <= CAC_START;
         idx           <= 4'd0;
         vs_q          <= 1'b1;
         avm_write     <= 1'b0;
         avm_address   <= 9'd0;
         avm_writedata <= 32'd0;
         frame_count   <= 16'd0;
      end else begin
         vs_q <= vga_vs;
         case (state)
            S_IDLE: begin
               avm_write <= 1'b0;
               if (tick) state <= S_UPDATE;
            end
            S_UPDATE: begin
               mode          <= mode_n;
               y             <= y_n;
               vy            <= vy_n;
               cac_x         <= cac_n;
               idx           <= 4'd0;
               avm_write     <= 1'b1;
               avm_address   <= 9'd0;
               avm_writedata <= {24'd0, reg_value(4'd0, mode_n, y_n, cac_n)};
               state         <= S_WRITE;
            end
            S_WRITE: begin
               if (avm_write && !avm_waitrequest) begin
                  if (idx == 4'd9) begin
                     avm_write   <= 1'b0;
                     frame_count <= frame_count + 16'd1;
                     state       <= S_IDLE;
                  end else begin
                     idx           <= idx + 4'd1;
                     avm_address   <= {5'd0, idx + 4'd1};
                     avm_writedata <= {24'd0, reg_value(idx + 4'd1, mode, y, cac_x)};
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dino_frame_writer.sv
// Directed and randomized frames against a plain-arithmetic game model for dino_frame_writer.
module tb_dino_frame_writer;

   localparam int P_DINO_X = 100, P_GROUND = 100, P_JUMP_V = 10, P_GRAV = 1;
   localparam int P_CAC_START = 250, P_CAC_Y = 100, P_SPEED = 4;
   localparam int P_GOD_X = 100, P_GOD_Y = 255, P_HIDE = 255;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vga_vs = 1'b1;
   logic        btn_jump = 1'b0;
   logic        btn_duck = 1'b0;
   logic [8:0]  avm_address;
   logic [31:0] avm_writedata;
   logic        avm_write;
   logic        avm_chipselect;
   logic        avm_waitrequest = 1'b0;
   logic        busy;
   logic [15:0] frame_count;

   dino_frame_writer dut (
      .clk(clk), .reset(reset), .vga_vs(vga_vs), .btn_jump(btn_jump), .btn_duck(btn_duck),
      .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_write(avm_write),
      .avm_chipselect(avm_chipselect), .avm_waitrequest(avm_waitrequest),
      .busy(busy), .frame_count(frame_count)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // game model
   int  m_y, m_vy, m_cac, m_frames;
   bit  in_jump, in_duck;
   int  exp_val[10];
   logic [31:0] got_addr[10];
   logic [31:0] got_data[10];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_y = P_GROUND; m_vy = 0; m_cac = P_CAC_START; m_frames = 0;
      in_jump = 0; in_duck = 0;
   endtask

   task automatic model_frame(input bit j, input bit d);
      int ny, pv;
      bit run;
      if (!in_jump) begin
         if (j) begin
            in_jump = 1; in_duck = 0; m_vy = -P_JUMP_V;
         end else begin
            in_duck = d;
         end
      end
      if (in_jump) begin
         ny = m_y + m_vy;
         pv = m_vy;
         m_vy = m_vy + P_GRAV;
         if (pv > 0 && ny >= P_GROUND) begin
            m_y = P_GROUND; m_vy = 0; in_jump = 0;
         end else begin
            m_y = ny;
         end
      end
      m_cac = (m_cac < P_SPEED) ? P_CAC_START : m_cac - P_SPEED;
      m_frames = (m_frames + 1) % 65536;
      run = !in_jump && !in_duck;
      exp_val[0] = run ? P_DINO_X : P_HIDE;
      exp_val[1] = run ? m_y : P_HIDE;
      exp_val[2] = in_jump ? P_DINO_X : P_HIDE;
      exp_val[3] = in_jump ? m_y : P_HIDE;
      exp_val[4] = in_duck ? P_DINO_X : P_HIDE;
      exp_val[5] = in_duck ? P_GROUND : P_HIDE;
      exp_val[6] = m_cac;
      exp_val[7] = P_CAC_Y;
      exp_val[8] = P_GOD_X;
      exp_val[9] = P_GOD_Y;
   endtask

   task automatic do_reset();
      reset = 1'b1; vga_vs = 1'b1; avm_waitrequest = 1'b0;
      btn_jump = 1'b0; btn_duck = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   // One frame: falling edge, collect ten beats with optional stall on address 4.
   task automatic run_frame(input bit j, input bit d, input int stall_n, input bit extra, input bit scramble);
      int nb, stall_left, t0;
      bit was_stall;
      btn_jump = j; btn_duck = d;
      model_frame(j, d);
      @(posedge clk); #1;
      vga_vs = 1'b0;
      t0 = cyc;
      nb = 0; stall_left = stall_n; was_stall = 0;
      avm_waitrequest = 1'b0;
      for (int c = 0; c < 200 && nb < 10; c++) begin
         @(posedge clk); #1;
         if (c == 0) check("busy_in_update", busy, 1);
         if (c == 1) vga_vs = 1'b1;
         if (extra && c == 5) vga_vs = 1'b0;
         if (extra && c == 7) vga_vs = 1'b1;
         if (scramble && c >= 1) begin
            btn_jump = (($urandom % 2) == 1);
            btn_duck = (($urandom % 2) == 1);
         end
         if (was_stall) begin
            check("stall_write", avm_write, 1);
            check("stall_addr", avm_address, 4);
            check("stall_data", avm_writedata, exp_val[4]);
         end
         if (avm_write && avm_address == 9'd4 && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
         end else begin
            avm_waitrequest = 1'b0;
         end
         was_stall = avm_waitrequest;
         if (avm_write && !avm_waitrequest) begin
            got_addr[nb] = avm_address;
            got_data[nb] = avm_writedata;
            if (nb == 0) check("chipselect", avm_chipselect, 1);
            if (nb == 0 && stall_n == 0) check("first_beat_latency", cyc - t0, 2);
            if (nb == 9 && stall_n == 0) check("last_beat_latency", cyc - t0, 11);
            nb++;
         end
      end
      avm_waitrequest = 1'b0;
      vga_vs = 1'b1;
      check("beat_count", nb, 10);
      for (int i = 0; i < nb; i++) begin
         check($sformatf("addr[%0d]", i), got_addr[i], i);
         check($sformatf("data[%0d]", i), got_data[i], exp_val[i]);
      end
      @(posedge clk); #1;
      check("idle_write", avm_write, 0);
      check("idle_busy", busy, 0);
      check("frame_count", frame_count, m_frames);
   endtask

   int jump_y[20] = '{90, 81, 73, 66, 60, 55, 51, 48, 46, 45, 45, 46, 48, 51, 55, 60, 66, 73, 81, 90};

   initial begin
      int  nb;
      bit  saw;
      bit  bj, bd;
      int  st;

      // reset state and quiet idle
      do_reset();
      check("rst_write", avm_write, 0);
      check("rst_cs", avm_chipselect, 0);
      check("rst_addr", avm_address, 0);
      check("rst_data", avm_writedata, 0);
      check("rst_busy", busy, 0);
      check("rst_fc", frame_count, 0);
      saw = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (avm_write || busy) saw = 1;
      end
      check("idle_1000_no_write", saw, 0);
      check("idle_1000_fc", frame_count, 0);

      // first frame, no buttons
      run_frame(0, 0, 0, 0, 0);
      check("f1_run_x", got_data[0], 100);
      check("f1_run_y", got_data[1], 100);
      check("f1_jump_y", got_data[3], 255);
      check("f1_cac", got_data[6], 246);

      // cactus wrap
      for (int f = 2; f <= 63; f++) begin
         run_frame(0, 0, 0, 0, 0);
         if (f == 62) check("cac_f62", got_data[6], 2);
         if (f == 63) check("cac_f63_wrap", got_data[6], 250);
      end

      // jump arc
      do_reset();
      for (int f = 1; f <= 21; f++) begin
         run_frame(f == 1, 0, 0, 0, 0);
         if (f <= 20) check($sformatf("jump_y_f%0d", f), got_data[3], jump_y[f-1]);
         if (f == 21) begin
            check("land_run_y", got_data[1], 100);
            check("land_jump_hidden", got_data[3], 255);
         end
      end

      // jump beats duck
      do_reset();
      run_frame(1, 1, 0, 0, 0);
      check("both_jump_x", got_data[2], 100);
      check("both_duck_hidden", got_data[4], 255);

      // duck alone, then release
      do_reset();
      run_frame(0, 1, 0, 0, 0);
      check("duck_x", got_data[4], 100);
      check("duck_y", got_data[5], 100);
      check("duck_run_hidden", got_data[0], 255);
      check("duck_jump_hidden", got_data[3], 255);
      run_frame(0, 0, 0, 0, 0);
      check("unduck_run_x", got_data[0], 100);

      // stall on address 4 plus an extra vsync edge mid-sequence
      run_frame(0, 0, 5, 1, 0);
      saw = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (avm_write) saw = 1;
      end
      check("extra_edge_ignored", saw, 0);
      check("extra_edge_fc", frame_count, m_frames);

      // reset mid-sequence
      @(posedge clk); #1;
      vga_vs = 1'b0;
      nb = 0;
      for (int c = 0; c < 100 && nb < 4; c++) begin
         @(posedge clk); #1;
         if (c == 1) vga_vs = 1'b1;
         if (avm_write && !avm_waitrequest) nb++;
      end
      check("midrst_beats_seen", nb, 4);
      vga_vs = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_write", avm_write, 0);
      check("midrst_busy", busy, 0);
      check("midrst_fc", frame_count, 0);
      check("midrst_addr", avm_address, 0);
      reset = 1'b0;
      model_reset();
      saw = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (avm_write) saw = 1;
      end
      check("midrst_no_beats", saw, 0);

      // randomized frames with scrambled buttons outside UPDATE
      for (int f = 0; f < 60; f++) begin
         bj = (($urandom % 4) == 0);
         bd = (($urandom % 3) == 0);
         st = (($urandom % 4) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_frame(bj, bd, st, 0, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
